seg7_scan_reader: RTL and testbench

Sequential inverse of the timer's 7-segment decoder. It samples a time-multiplexed, active-low segment bus for the three timer digits (sec_ones, sec_tens, mins) and qualifies each digit by stability. It converts qualified patterns back to BCD and publishes a complete, coherent frame of three digits. It sits on the display side of the timer as a self-check and monitor block, so that displayed digits can be compared against the counter values.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_scan_reader_if.sv | 24 ++
 rtl/seg7_pattern_to_bcd.sv | 29 ++
 rtl/seg7_scan_reader.sv | 123 ++++++++++++
 tb/tb_seg7_scan_reader.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan reader: active-low segment codes,
// slot indices and the dwell FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  localparam int SLOT_SEC_ONES = 0;
  localparam int SLOT_SEC_TENS = 1;
  localparam int SLOT_MINS     = 2;
  localparam int NUM_SLOTS     = 3;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } scan_state_e;

  function automatic logic sel_is_onehot(input logic [2:0] sel);
    return (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
  endfunction

  // Nonzero but not one-hot: two or more digits driven at once.
  function automatic logic sel_is_invalid(input logic [2:0] sel);
    return (sel != 3'b000) && !sel_is_onehot(sel);
  endfunction

endpackage

// File: rtl/seg7_scan_reader_if.sv
// Display-side bus of the scan reader: multiplexed segment/select inputs and
// the published BCD frame with its status pulses.
interface seg7_scan_reader_if;

  logic [6:0] seg_in;
  logic [2:0] dig_sel;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] mins;
  logic       frame_valid;
  logic       pattern_err;
  logic       sel_err;

  modport master (
    output seg_in, dig_sel,
    input  sec_ones, sec_tens, mins, frame_valid, pattern_err, sel_err
  );

  modport slave (
    input  seg_in, dig_sel,
    output sec_ones, sec_tens, mins, frame_valid, pattern_err, sel_err
  );

endinterface

// File: rtl/seg7_pattern_to_bcd.sv
// Combinational reverse lookup from an active-low segment code to BCD;
// valid_o is low for any code that is not one of the ten digits.
module seg7_pattern_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] bcd_o,
  output logic       valid_o
);

  always_comb begin
    bcd_o   = 4'd0;
    valid_o = 1'b1;
    case (pattern_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Samples the multiplexed segment bus, judges each stable digit dwell once,
// and publishes the three digits together when a full frame has been captured.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_reader_if.slave   bus
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  logic [6:0]                      seg_q;
  logic [2:0]                      sel_q;
  logic [7:0]                      cnt_q, cnt_d;
  scan_state_e                     state_q, state_d;
  logic [NUM_SLOTS-1:0]            captured_q, captured_d;
  logic [NUM_SLOTS-1:0][3:0]       shadow_q, shadow_d;
  logic [NUM_SLOTS-1:0][3:0]       out_q, out_d;
  logic                            frame_valid_q, pattern_err_q, sel_err_q, sel_bad_q;
  logic                            change, judge, frame_done;
  logic [3:0]                      code_bcd;
  logic                            code_valid;

  seg7_pattern_to_bcd u_decode (
    .pattern_i (seg_q),
    .bcd_o     (code_bcd),
    .valid_o   (code_valid)
  );

  // A change is seen at the edge where the new value is registered.
  assign change = (bus.seg_in != seg_q) || (bus.dig_sel != sel_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    judge   = 1'b0;
    if (change) begin
      if (sel_is_onehot(bus.dig_sel)) begin
        state_d = SETTLE;
        cnt_d   = 8'd1;
      end else begin
        state_d = BLANK;
        cnt_d   = 8'd0;
      end
    end else begin
      case (state_q)
        SETTLE: begin
          if (cnt_q >= STABLE_LIM) begin
            judge   = 1'b1;
            state_d = HELD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // sel_q is one-hot whenever a judge happens, so it doubles as the slot mask.
  assign frame_done = judge && code_valid && ((captured_q | sel_q) == 3'b111);

  always_comb begin
    captured_d = captured_q;
    if (judge) begin
      if (!code_valid || frame_done) begin
        captured_d = '0;
      end else begin
        captured_d = captured_q | sel_q;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign shadow_d[gi] = (judge && code_valid && sel_q[gi]) ? code_bcd : shadow_q[gi];
    assign out_d[gi]    = frame_done ? shadow_d[gi] : out_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q         <= '0;
      sel_q         <= '0;
      cnt_q         <= '0;
      captured_q    <= '0;
      shadow_q      <= '0;
      out_q         <= '0;
      frame_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
      sel_err_q     <= 1'b0;
      sel_bad_q     <= 1'b0;
    end else begin
      seg_q         <= bus.seg_in;
      sel_q         <= bus.dig_sel;
      cnt_q         <= cnt_d;
      captured_q    <= captured_d;
      shadow_q      <= shadow_d;
      out_q         <= out_d;
      frame_valid_q <= frame_done;
      pattern_err_q <= judge && !code_valid;
      sel_bad_q     <= sel_is_invalid(sel_q);
      sel_err_q     <= sel_is_invalid(sel_q) && !sel_bad_q;
    end
  end

  assign bus.sec_ones    = out_q[SLOT_SEC_ONES];
  assign bus.sec_tens    = out_q[SLOT_SEC_TENS];
  assign bus.mins        = out_q[SLOT_MINS];
  assign bus.frame_valid = frame_valid_q;
  assign bus.pattern_err = pattern_err_q;
  assign bus.sel_err     = sel_err_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader with STABLE_CYCLES = 4; each hold() is
// one dwell of a select/segment pair, and pulses are tallied per dwell step.
module tb_seg7_scan_reader;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   step_idx;
  int   fv_n, pe_n, se_n;
  int   fv_step, pe_step, se_step;
  logic [3:0] fv_ones, fv_tens, fv_mins;

  seg7_scan_reader_if bus ();

  seg7_scan_reader #(.STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    fv_n = 0; pe_n = 0; se_n = 0;
    fv_step = 0; pe_step = 0; se_step = 0;
    fv_ones = 4'd0; fv_tens = 4'd0; fv_mins = 4'd0;
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    step_idx++;
    if (bus.frame_valid) begin
      fv_n++;
      fv_step = step_idx;
      fv_ones = bus.sec_ones;
      fv_tens = bus.sec_tens;
      fv_mins = bus.mins;
    end
    if (bus.pattern_err) begin
      pe_n++;
      pe_step = step_idx;
    end
    if (bus.sel_err) begin
      se_n++;
      se_step = step_idx;
    end
  endtask

  task automatic hold(input logic [2:0] sel, input logic [6:0] seg, input int n);
    bus.dig_sel = sel;
    bus.seg_in  = seg;
    step_idx    = 0;
    repeat (n) step();
    $display("hold sel=%b seg=%b cycles=%0d -> out=%0d/%0d/%0d fv=%0d perr=%0d serr=%0d",
             sel, seg, n, bus.mins, bus.sec_tens, bus.sec_ones, fv_n, pe_n, se_n);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    step_idx = 0;
    clr();
    rst         = 1'b1;
    bus.dig_sel = 3'b000;
    bus.seg_in  = 7'b1111111;

    // Reset for two cycles, then idle.
    repeat (2) step();
    check("rst_ones", bus.sec_ones, 0);
    check("rst_tens", bus.sec_tens, 0);
    check("rst_mins", bus.mins, 0);
    check("rst_fv", bus.frame_valid, 0);
    check("rst_perr", bus.pattern_err, 0);
    check("rst_serr", bus.sel_err, 0);
    rst = 1'b0;
    clr();
    repeat (20) step();
    check("idle_fv", fv_n, 0);
    check("idle_pulses", pe_n + se_n, 0);

    // Full scan 7/3/2.
    clr();
    hold(3'b001, 7'b0001111, 6);
    hold(3'b010, 7'b0000110, 6);
    check("scan1_early_fv", fv_n, 0);
    check("scan1_early_ones", bus.sec_ones, 0);
    hold(3'b100, 7'b0010010, 6);
    check("scan1_fv_count", fv_n, 1);
    check("scan1_fv_edge", fv_step, 5);
    check("scan1_ones", fv_ones, 7);
    check("scan1_tens", fv_tens, 3);
    check("scan1_mins", fv_mins, 2);
    check("scan1_perr", pe_n, 0);

    // Mins dwell of only 4 cycles is ignored; later full dwell publishes 5/5/9.
    clr();
    hold(3'b001, 7'b0100100, 6);
    hold(3'b010, 7'b0100100, 6);
    hold(3'b100, 7'b0000000, 4);
    hold(3'b000, 7'b1111111, 2);
    check("short_fv", fv_n, 0);
    check("short_keep_ones", bus.sec_ones, 7);
    hold(3'b100, 7'b0000100, 6);
    check("scan2_fv_count", fv_n, 1);
    check("scan2_fv_edge", fv_step, 5);
    check("scan2_ones", fv_ones, 5);
    check("scan2_tens", fv_tens, 5);
    check("scan2_mins", fv_mins, 9);

    // Invalid pattern discards the partial frame.
    clr();
    hold(3'b001, 7'b1001111, 6);
    hold(3'b010, 7'b1001100, 6);
    hold(3'b001, 7'b1111111, 8);
    check("perr_count", pe_n, 1);
    check("perr_edge", pe_step, 5);
    check("perr_fv", fv_n, 0);
    hold(3'b100, 7'b0100000, 6);
    check("perr_discard_fv", fv_n, 0);
    check("perr_keep_mins", bus.mins, 9);
    hold(3'b001, 7'b0000001, 6);
    hold(3'b010, 7'b0000100, 6);
    check("scan3_fv_count", fv_n, 1);
    check("scan3_ones", fv_ones, 0);
    check("scan3_tens", fv_tens, 9);
    check("scan3_mins", fv_mins, 6);

    // Two digits selected at once.
    clr();
    hold(3'b011, 7'b0000000, 10);
    check("serr_count", se_n, 1);
    check("serr_edge", se_step, 2);
    check("serr_fv", fv_n, 0);
    check("serr_perr", pe_n, 0);
    hold(3'b001, 7'b0000110, 6);
    hold(3'b010, 7'b0000001, 6);
    hold(3'b100, 7'b1001111, 6);
    check("scan4_fv_count", fv_n, 1);
    check("scan4_ones", fv_ones, 3);
    check("scan4_tens", fv_tens, 0);
    check("scan4_mins", fv_mins, 1);

    // Mid-frame reset.
    clr();
    hold(3'b001, 7'b0010010, 6);
    hold(3'b010, 7'b1001100, 6);
    rst         = 1'b1;
    bus.dig_sel = 3'b000;
    bus.seg_in  = 7'b1111111;
    step();
    check("mrst_ones", bus.sec_ones, 0);
    check("mrst_pulses", bus.frame_valid + bus.pattern_err + bus.sel_err, 0);
    rst = 1'b0;
    hold(3'b100, 7'b0100100, 6);
    check("mrst_fv", fv_n, 0);
    check("mrst_mins", bus.mins, 0);
    check("mrst_tens", bus.sec_tens, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
